uart_rx_buffered: RTL and testbench

- 8N1 UART receiver with a receive FIFO; the receive-side counterpart to the processor's UART transmit peripheral.
- Deserialises the external serial line and buffers the bytes.
- Presents the FIFO head to the processor's load path as a 32-bit word; a one-cycle read strobe pops it.
- Sits beside the data memory in the datapath and is selected by address decode outside this block.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_rx_buffered_if.sv | 27 ++
 rtl/uart_rx_fifo.sv | 58 +++++
 rtl/uart_rx_buffered.sv | 153 +++++++++++++++
 tb/tb_uart_rx_buffered.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and receiver state encoding
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_t;

    localparam logic [31:0] RX_EMPTY_WORD        = 32'hFFFF_FFFF;
    localparam int          DATA_BITS            = 8;
    localparam int          DEFAULT_CLKS_PER_BIT = 10417;

endpackage

// File: rtl/uart_rx_buffered_if.sv
// rtl/uart_rx_buffered_if.sv - processor load-path bundle of the buffered UART receiver
interface uart_rx_buffered_if #(
    parameter int FIFO_DEPTH = 16
) ();

    logic                          rd_en;
    logic                          err_clr;
    logic [31:0]                   rd_data;
    logic [$clog2(FIFO_DEPTH):0]   rx_count;
    logic                          rx_empty;
    logic                          rx_full;
    logic                          frame_err;
    logic                          overrun_err;

    // Processor side: issues pops and error clears, observes data and status
    modport master (
        output rd_en, err_clr,
        input  rd_data, rx_count, rx_empty, rx_full, frame_err, overrun_err
    );

    // Receiver side
    modport slave (
        input  rd_en, err_clr,
        output rd_data, rx_count, rx_empty, rx_full, frame_err, overrun_err
    );

endinterface

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - show-ahead synchronous FIFO for received bytes
module uart_rx_fifo #(
    parameter int WIDTH      = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push,
    input  logic [WIDTH-1:0]              push_data,
    input  logic                          pop,
    output logic [WIDTH-1:0]              head,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          empty,
    output logic                          full
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             pop_ok;
    logic             push_ok;

    // A pop in the same cycle frees a slot, so a push into a full FIFO is still accepted
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    assign empty = (count == '0);
    assign full  = (count == CW'(FIFO_DEPTH));
    assign head  = mem[rd_ptr];

    // Storage is written only on an accepted push
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally at FIFO_DEPTH; occupancy tracked separately
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

endmodule

// File: rtl/uart_rx_buffered.sv
// rtl/uart_rx_buffered.sv - 8N1 UART receiver feeding a show-ahead receive FIFO
module uart_rx_buffered
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                rx,
    uart_rx_buffered_if.slave   bus
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam int CW    = $clog2(FIFO_DEPTH) + 1;

    localparam logic [CNT_W-1:0] HALF_MAX = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_MAX  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(DATA_BITS - 1);

    logic                 rx_meta;
    logic                 rxs;
    rx_state_t            state;
    rx_state_t            state_nxt;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     cnt_nxt;
    logic [IDX_W-1:0]     bit_idx;
    logic [IDX_W-1:0]     bit_idx_nxt;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] shreg_nxt;
    logic                 push;
    logic                 frame_set;
    logic                 overrun_set;
    logic                 frame_err_q;
    logic                 overrun_err_q;
    logic [DATA_BITS-1:0] head;
    logic [CW-1:0]        count;
    logic                 empty;
    logic                 full;

    // Two-flop synchronizer; idle-high so reset leaves the line looking idle
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    // Receiver state, baud counter, bit index and shift register
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_idx <= bit_idx_nxt;
            shreg   <= shreg_nxt;
        end
    end

    // Frame decoding: start validated at half a bit, data and stop sampled a full bit apart
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt + 1'b1;
        bit_idx_nxt = bit_idx;
        shreg_nxt   = shreg;
        push        = 1'b0;
        frame_set   = 1'b0;
        overrun_set = 1'b0;
        case (state)
            ST_IDLE: begin
                cnt_nxt = '0;
                if (!rxs) begin
                    state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (cnt == HALF_MAX) begin
                    cnt_nxt     = '0;
                    bit_idx_nxt = '0;
                    state_nxt   = rxs ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (cnt == BIT_MAX) begin
                    cnt_nxt     = '0;
                    shreg_nxt   = {rxs, shreg[DATA_BITS-1:1]};
                    bit_idx_nxt = bit_idx + 1'b1;
                    if (bit_idx == LAST_BIT) begin
                        state_nxt = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (cnt == BIT_MAX) begin
                    cnt_nxt   = '0;
                    state_nxt = ST_IDLE;
                    if (!rxs) begin
                        frame_set = 1'b1;
                    end else if (full && !bus.rd_en) begin
                        overrun_set = 1'b1;
                    end else begin
                        push = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Sticky error flags; a set event on the clearing edge wins
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_err_q   <= 1'b0;
            overrun_err_q <= 1'b0;
        end else begin
            frame_err_q   <= frame_set   | (frame_err_q   & ~bus.err_clr);
            overrun_err_q <= overrun_set | (overrun_err_q & ~bus.err_clr);
        end
    end

    uart_rx_fifo #(
        .WIDTH      (DATA_BITS),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (shreg),
        .pop       (bus.rd_en),
        .head      (head),
        .count     (count),
        .empty     (empty),
        .full      (full)
    );

    assign bus.rd_data     = empty ? RX_EMPTY_WORD : {{(32 - DATA_BITS){1'b0}}, head};
    assign bus.rx_count    = count;
    assign bus.rx_empty    = empty;
    assign bus.rx_full     = full;
    assign bus.frame_err   = frame_err_q;
    assign bus.overrun_err = overrun_err_q;

endmodule

// File: tb/tb_uart_rx_buffered.sv
// tb/tb_uart_rx_buffered.sv - self-checking bench for uart_rx_buffered
module tb_uart_rx_buffered;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    logic clk;
    logic reset;
    logic rx;

    int npass  = 0;
    int ntotal = 0;

    logic [7:0] mq[$];
    logic       m_fe;
    logic       m_oe;

    uart_rx_buffered_if #(.FIFO_DEPTH(DEPTH)) bus ();

    uart_rx_buffered #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .rx    (rx),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] exp_word();
        return (mq.size() > 0) ? {24'h0, mq[0]} : 32'hFFFF_FFFF;
    endfunction

    function automatic logic line_bit(input logic [7:0] b, input logic stop, input int t);
        if (t < CPB)            return 1'b0;
        else if (t < 9 * CPB)   return b[(t - CPB) / CPB];
        else if (t < FRAME)     return stop;
        else                    return 1'b1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".count"},   32'(bus.rx_count),  32'(mq.size()));
        chk({tag, ".empty"},   32'(bus.rx_empty),  32'(mq.size() == 0));
        chk({tag, ".full"},    32'(bus.rx_full),   32'(mq.size() == DEPTH));
        chk({tag, ".rd_data"}, bus.rd_data,        exp_word());
        chk({tag, ".fe"},      32'(bus.frame_err), 32'(m_fe));
        chk({tag, ".oe"},      32'(bus.overrun_err), 32'(m_oe));
    endtask

    // Drives one frame from a negedge; pop_at_push pulses rd_en on the edge the byte lands
    task automatic send(input logic [7:0] b, input logic stop, input bit pop_at_push);
        for (int t = 0; t < FRAME + 4; t++) begin
            rx        = line_bit(b, stop, t);
            bus.rd_en = (pop_at_push && t == FRAME - 6);
            if (t == FRAME - 6) begin
                chk("pre_push.count", 32'(bus.rx_count), 32'(mq.size()));
            end
            if (t == FRAME - 5) begin
                if (pop_at_push && mq.size() > 0) void'(mq.pop_front());
                if (!stop)                  m_fe = 1'b1;
                else if (mq.size() < DEPTH) mq.push_back(b);
                else                        m_oe = 1'b1;
                chk("post_push.count", 32'(bus.rx_count), 32'(mq.size()));
                chk("post_push.rd_data", bus.rd_data, exp_word());
            end
            @(negedge clk);
        end
        bus.rd_en = 1'b0;
    endtask

    task automatic pop();
        chk("pop.head", bus.rd_data, exp_word());
        bus.rd_en = 1'b1;
        @(negedge clk);
        bus.rd_en = 1'b0;
        if (mq.size() > 0) void'(mq.pop_front());
    endtask

    task automatic clear_err();
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        m_fe = 1'b0;
        m_oe = 1'b0;
    endtask

    initial begin
        logic [7:0] rb;
        logic       rstop;
        bit         rpap;

        rx          = 1'b1;
        reset       = 1'b1;
        bus.rd_en   = 1'b0;
        bus.err_clr = 1'b0;
        m_fe        = 1'b0;
        m_oe        = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_all("reset");

        // single byte, pop, pop on empty
        send(8'hA5, 1'b1, 1'b0);
        check_all("t1.rx");
        pop();
        check_all("t1.pop");
        pop();
        check_all("t1.pop_empty");

        // fill, overrun, drain in order
        send(8'h01, 1'b1, 1'b0);
        send(8'h80, 1'b1, 1'b0);
        send(8'hFF, 1'b1, 1'b0);
        send(8'h3C, 1'b1, 1'b0);
        check_all("t2.full");
        send(8'h55, 1'b1, 1'b0);
        check_all("t2.overrun");
        repeat (4) pop();
        check_all("t2.drained");

        // push into full FIFO while popping the same edge
        clear_err();
        check_all("t3.clr");
        send(8'h01, 1'b1, 1'b0);
        send(8'h80, 1'b1, 1'b0);
        send(8'hFF, 1'b1, 1'b0);
        send(8'h3C, 1'b1, 1'b0);
        send(8'h77, 1'b1, 1'b1);
        check_all("t3.simul");
        repeat (4) pop();
        check_all("t3.drained");

        // framing error, clear, recovery
        send(8'h5A, 1'b0, 1'b0);
        check_all("t4.fe");
        clear_err();
        check_all("t4.clr");
        send(8'h12, 1'b1, 1'b0);
        check_all("t4.rx");
        pop();

        // short low glitch is rejected
        rx = 1'b0;
        repeat (5) @(negedge clk);
        rx = 1'b1;
        repeat (30) @(negedge clk);
        check_all("t5.glitch");
        send(8'h33, 1'b1, 1'b0);
        check_all("t5.rx");
        pop();

        // reset mid-frame; held across the low run so the tail cannot form a start bit
        send(8'hE1, 1'b1, 1'b0);
        send(8'h9D, 1'b1, 1'b0);
        send(8'h00, 1'b0, 1'b0);
        check_all("t6.pre");
        for (int t = 0; t < FRAME + 4; t++) begin
            rx    = line_bit(8'hC3, 1'b1, t);
            reset = (t >= 40 && t < 116);
            if (t == 41) begin
                mq.delete();
                m_fe = 1'b0;
                m_oe = 1'b0;
            end
            if (t == 60) check_all("t6.in_reset");
            @(negedge clk);
        end
        reset = 1'b0;
        check_all("t6.after");
        send(8'h44, 1'b1, 1'b0);
        check_all("t6.rx");
        pop();

        // randomized frames against the queue model
        for (int i = 0; i < 24; i++) begin
            rb    = 8'($urandom_range(0, 255));
            rstop = ($urandom_range(0, 7) != 0);
            rpap  = ($urandom_range(0, 3) == 0);
            send(rb, rstop, rpap);
            check_all("rnd.frame");
            for (int p = 0; p < int'($urandom_range(0, 2)); p++) pop();
            if ($urandom_range(0, 4) == 0) clear_err();
            check_all("rnd.after");
        end

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
